shift_deser_ctrl: RTL

SHIFT_DESER_CTRL -- requirements
Module: shift_deser_ctrl

---
 rtl/shift_deser_ctrl.sv | 107 ++++++++++
 1 files changed

// File: rtl/shift_deser_ctrl.sv
// Serial-to-parallel frame deserializer: shifts in p_nbits MSB-first bits, then holds the
// assembled frame until a valid/ready handshake. Stray input while holding sets a sticky overrun.
module shift_deser_ctrl #(
    parameter int unsigned p_nbits       = 8,
    parameter logic        p_reset_value = 1'b0
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               s_bit,
    input  logic                               s_bit_val,
    input  logic                               s_start,
    output logic [p_nbits-1:0]                 out_msg,
    output logic                               out_val,
    input  logic                               out_rdy,
    output logic                               busy,
    output logic                               overrun,
    output logic [$clog2(p_nbits+1)-1:0]       bit_count
);

    localparam int unsigned CntW = $clog2(p_nbits + 1);
    localparam logic [p_nbits-1:0] FrameClr = {p_nbits{p_reset_value}};
    localparam logic [CntW-1:0]    LastIdx  = CntW'(p_nbits - 1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StHold
    } state_e;

    state_e              state_q, state_d;
    logic [p_nbits-1:0]  frame_q, frame_d;
    logic [CntW-1:0]     count_q, count_d;
    logic                overrun_q, overrun_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            frame_q   <= FrameClr;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        count_d   = count_q;
        overrun_d = overrun_q;

        unique case (state_q)
            StIdle: begin
                if (s_start) begin
                    state_d = StShift;
                    frame_d = FrameClr;
                    count_d = '0;
                end
            end

            StShift: begin
                // A restart wins over a bit arriving in the same cycle.
                if (s_start) begin
                    frame_d = FrameClr;
                    count_d = '0;
                end else if (s_bit_val) begin
                    frame_d = {frame_q[p_nbits-2:0], s_bit};
                    count_d = count_q + CntW'(1);
                    if (count_q == LastIdx) begin
                        state_d = StHold;
                    end
                end
            end

            StHold: begin
                if (s_bit_val) begin
                    overrun_d = 1'b1;
                end
                if (out_rdy) begin
                    count_d = '0;
                    if (s_start) begin
                        state_d = StShift;
                        frame_d = FrameClr;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (s_start) begin
                    overrun_d = 1'b1;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign out_msg   = frame_q;
    assign out_val   = (state_q == StHold);
    assign busy      = (state_q != StIdle);
    assign overrun   = overrun_q;
    assign bit_count = count_q;

endmodule
